// File: rtl/hazard_ctrl.sv
// ID/EX sequencing controller: load-use stalls, MDU occupancy freeze, branch/jump squashes.
// Optional build macro HAZARD_CTRL_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       ex_mdu_start,
    input  logic       id_jump,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_bubble,
    output logic       busy
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_BUSY = 1'b1;

    // The start cycle itself is frozen in RUN, so the counter covers the remaining L-2 cycles.
    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'((MDU_LATENCY >= 3) ? (MDU_LATENCY - 2) : 0);

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] mdu_cnt, mdu_cnt_nxt;
    logic             load_use;
    logic             mdu_stall;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mdu_stall = ex_mdu_start && (MDU_LATENCY >= 2);
    assign busy      = (state == ST_MDU_BUSY);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_nxt    = state;
        mdu_cnt_nxt  = mdu_cnt;
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == ST_MDU_BUSY) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            mdu_cnt_nxt = mdu_cnt - CNT_W'(1);
            if (mdu_cnt == CNT_W'(1)) state_nxt = ST_RUN;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mdu_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            if (MDU_LATENCY >= 3) begin
                mdu_cnt_nxt = MDU_LOAD;
                state_nxt   = ST_MDU_BUSY;
            end
        end else if (load_use) begin
            // One cycle suffices: the bubble inserted now is what sits in EX next cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four instances (MDU_LATENCY 4, 1, 2, 8) share one stimulus stream;
// expected control vectors are queued when stimulus is driven and compared after the outputs settle.
module tb_hazard_ctrl;

    // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, busy}
    localparam logic [5:0] V_RUN   = 6'b110100;
    localparam logic [5:0] V_LU    = 6'b000110;
    localparam logic [5:0] V_MDU   = 6'b000000;
    localparam logic [5:0] V_BUSY  = 6'b000001;
    localparam logic [5:0] V_BR    = 6'b111110;
    localparam logic [5:0] V_JMP   = 6'b111100;
    localparam logic [5:0] V_RST   = 6'b001010;

    localparam int S4 = 0, S1 = 1, S2 = 2, S8 = 3, SC4 = 4, FC4 = 5;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_mdu_start = 1'b0;
    logic       id_jump = 1'b0, ex_branch_taken = 1'b0;

    wire [5:0] v4, v1, v2, v8;
`ifdef HAZARD_CTRL_PERF_EN
    wire [15:0] sc4, fc4, sc1, fc1, sc2, fc2, sc8, fc8;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    always #5 clock = ~clock;

    hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(16)) u4 (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .pc_write(v4[5]), .if_id_write(v4[4]), .if_id_flush(v4[3]),
        .id_ex_write(v4[2]), .id_ex_bubble(v4[1]), .busy(v4[0])
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_count(sc4), .flush_count(fc4)
`endif
    );

    hazard_ctrl #(.MDU_LATENCY(1), .CNT_W(16)) u1 (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .pc_write(v1[5]), .if_id_write(v1[4]), .if_id_flush(v1[3]),
        .id_ex_write(v1[2]), .id_ex_bubble(v1[1]), .busy(v1[0])
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    hazard_ctrl #(.MDU_LATENCY(2), .CNT_W(16)) u2 (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .pc_write(v2[5]), .if_id_write(v2[4]), .if_id_flush(v2[3]),
        .id_ex_write(v2[2]), .id_ex_bubble(v2[1]), .busy(v2[0])
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_count(sc2), .flush_count(fc2)
`endif
    );

    hazard_ctrl #(.MDU_LATENCY(8), .CNT_W(16)) u8 (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .pc_write(v8[5]), .if_id_write(v8[4]), .if_id_flush(v8[3]),
        .id_ex_write(v8[2]), .id_ex_bubble(v8[1]), .busy(v8[0])
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_count(sc8), .flush_count(fc8)
`endif
    );

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            S4:      return {26'd0, v4};
            S1:      return {26'd0, v1};
            S2:      return {26'd0, v2};
            S8:      return {26'd0, v8};
`ifdef HAZARD_CTRL_PERF_EN
            SC4:     return {16'd0, sc4};
            FC4:     return {16'd0, fc4};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Apply one cycle of stimulus just after the falling edge.
    task automatic drive(input logic rn, input logic br, input logic jmp, input logic mr,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic mdu);
        @(negedge clock);
        reset_n         = rn;
        ex_branch_taken = br;
        id_jump         = jmp;
        ex_mem_read     = mr;
        ex_rd           = rd;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_mdu_start    = mdu;
    endtask

    task automatic idle(input logic rn);
        drive(rn, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
        sbq.push_back('{tag, sel, val});
    endtask

    // Compare everything queued for this cycle, mid low phase, away from the rising edge.
    task automatic check_now();
        exp_t e;
        logic [31:0] obs;
        #2;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observed(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%b expected=%b", e.tag, obs[5:0], e.val[5:0]);
            end
        end
    endtask

    initial begin
        // Reset values on every instance
        idle(1'b0);
        expect_v("rst_u4", S4, V_RST); expect_v("rst_u1", S1, V_RST);
        expect_v("rst_u2", S2, V_RST); expect_v("rst_u8", S8, V_RST);
        check_now();

        idle(1'b1);
        expect_v("run_u4", S4, V_RUN); expect_v("run_u8", S8, V_RUN);
        check_now();

        // Load-use on rs, one cycle only
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        expect_v("lu_rs", S4, V_LU); check_now();
        idle(1'b1);
        expect_v("lu_after", S4, V_RUN); check_now();

        // Register 0 and unused rt never stall; used rt does
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_v("lu_r0", S4, V_RUN); check_now();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
        expect_v("lu_rt_unused", S4, V_RUN); check_now();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
        expect_v("lu_rt_used", S4, V_LU); check_now();

        // Branch beats load-use and jump
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        expect_v("br_prio", S4, V_BR); check_now();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_v("jump", S4, V_JMP); check_now();

        // MDU start coincident with load-use: MDU wins unless latency 1
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        expect_v("mdu_t_u4", S4, V_MDU); expect_v("mdu_t_u2", S2, V_MDU);
        expect_v("mdu_t_u1_lu", S1, V_LU); expect_v("mdu_t_u8", S8, V_MDU);
        check_now();
        idle(1'b1);
        expect_v("mdu_t1_u4", S4, V_BUSY); expect_v("mdu_t1_u2", S2, V_RUN);
        expect_v("mdu_t1_u1", S1, V_RUN); expect_v("mdu_t1_u8", S8, V_BUSY);
        check_now();
        // Branch and new MDU start ignored while busy
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_v("mdu_t2_u4_ign", S4, V_BUSY); expect_v("mdu_t2_u2_br", S2, V_BR);
        expect_v("mdu_t2_u1_br", S1, V_BR); expect_v("mdu_t2_u8", S8, V_BUSY);
        check_now();
        idle(1'b1);
        expect_v("mdu_t3_u4", S4, V_RUN); expect_v("mdu_t3_u8", S8, V_BUSY); check_now();
        idle(1'b1); idle(1'b1);
        idle(1'b1);
        expect_v("mdu8_last", S8, V_BUSY); check_now();
        idle(1'b1);
        expect_v("mdu8_done", S8, V_RUN); expect_v("mdu8_done_u4", S4, V_RUN); check_now();

        // Plain MDU pulse, then asynchronous reset while latency-8 instance is busy
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_v("p_t_u8", S8, V_MDU); expect_v("p_t_u1_nostall", S1, V_RUN);
        expect_v("p_t_u2", S2, V_MDU);
        check_now();
        idle(1'b1);
        expect_v("p_t1_u8", S8, V_BUSY); expect_v("p_t1_u2_nobusy", S2, V_RUN); check_now();
        idle(1'b0);
        expect_v("midrst_u8", S8, V_RST); expect_v("midrst_u4", S4, V_RST); check_now();
        idle(1'b1);
        expect_v("postrst_u8", S8, V_RUN); expect_v("postrst_u4", S4, V_RUN); check_now();
        idle(1'b1);
        expect_v("postrst2_u8", S8, V_RUN); check_now();

        // Counter sequence: 2 load-use stalls, one MDU op (3 frozen cycles), 3 jumps
        idle(1'b0);
`ifdef HAZARD_CTRL_PERF_EN
        expect_v("sc_rst", SC4, 32'd0); expect_v("fc_rst", FC4, 32'd0);
`endif
        check_now();
        idle(1'b1);
        expect_v("perf_run", S4, V_RUN); check_now();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        expect_v("perf_lu1", S4, V_LU); check_now();
        idle(1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
        expect_v("perf_lu2", S4, V_LU); check_now();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_v("perf_mdu", S4, V_MDU); check_now();
        idle(1'b1); idle(1'b1);
        idle(1'b1);
        expect_v("perf_mdu_end", S4, V_RUN); check_now();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            expect_v("perf_jmp", S4, V_JMP); check_now();
        end
        idle(1'b1);
`ifdef HAZARD_CTRL_PERF_EN
        expect_v("stall_count", SC4, 32'd5); expect_v("flush_count", FC4, 32'd3);
`endif
        expect_v("perf_end", S4, V_RUN);
        check_now();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
